// File: rtl/coherent_iq_demod_if.sv
// Sample/result bus of the coherent I/Q demodulator.
// master drives samples and carrier refs and reads back symbol results; slave is the demodulator side.
interface coherent_iq_demod_if #(
    parameter int DATA_W = 10,
    parameter int ACC_W  = 28
);
    logic signed [DATA_W-1:0] sample_in;
    logic signed [DATA_W-1:0] sin_ref;
    logic signed [DATA_W-1:0] cos_ref;
    logic                     sample_vld;
    logic                     sym_sync;
    logic signed [ACC_W-1:0]  i_sum;
    logic signed [ACC_W-1:0]  q_sum;
    logic                     bit_i;
    logic                     bit_q;
    logic                     sym_vld;

    modport master (
        output sample_in, sin_ref, cos_ref, sample_vld, sym_sync,
        input  i_sum, q_sum, bit_i, bit_q, sym_vld
    );

    modport slave (
        input  sample_in, sin_ref, cos_ref, sample_vld, sym_sync,
        output i_sum, q_sum, bit_i, bit_q, sym_vld
    );
endinterface

// File: rtl/coherent_iq_demod.sv
// Coherent I/Q demodulator: mix with local sin/cos, integrate one symbol, dump and hard-decide.
// Ports: clk, rst (async, active high), bus (slave: samples/refs/valid/sync in, sums/bits/sym_vld out).
module coherent_iq_demod #(
    parameter int DATA_W     = 10,
    parameter int SYMBOL_LEN = 200,
    parameter int CNT_W      = 8,
    parameter int ACC_W      = 28
) (
    input  logic                clk,
    input  logic                rst,
    coherent_iq_demod_if.slave  bus
);
    localparam int PW = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMBOL_LEN - 1);

    // FLUSH lasts exactly the edge at which sym_sync is sampled, so the
    // mode is decoded straight from sym_sync; ACCUM resumes on the next edge.
    typedef enum logic {ACCUM, FLUSH} mode_e;
    mode_e mode;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [PW-1:0] prod_i_q, prod_i_d;
    logic signed [PW-1:0] prod_q_q, prod_q_d;
    logic                 s1_vld_q, s1_vld_d;
    logic                 s1_last_q, s1_last_d;

    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0] i_sum_q, i_sum_d;
    logic signed [ACC_W-1:0] q_sum_q, q_sum_d;
    logic                    bit_i_q, bit_i_d;
    logic                    bit_q_q, bit_q_d;
    logic                    sym_vld_q, sym_vld_d;

    logic signed [ACC_W-1:0] ext_i, ext_q;
    logic signed [ACC_W-1:0] sum_i, sum_q;

    always_comb begin
        mode = bus.sym_sync ? FLUSH : ACCUM;
    end

    // Stage 1: multiply and tag the last sample of the symbol.
    always_comb begin
        cnt_d     = cnt_q;
        prod_i_d  = prod_i_q;
        prod_q_d  = prod_q_q;
        s1_vld_d  = 1'b0;
        s1_last_d = 1'b0;
        if (mode == FLUSH) begin
            cnt_d = '0;
        end
        if (bus.sample_vld) begin
            s1_vld_d = 1'b1;
            prod_i_d = PW'(bus.sample_in) * PW'(bus.cos_ref);
            prod_q_d = PW'(bus.sample_in) * PW'(bus.sin_ref);
            if (mode == FLUSH) begin
                // Sample arriving with the resync is sample 1 of the new symbol.
                cnt_d = CNT_W'(1);
            end else if (cnt_q == LAST_CNT) begin
                cnt_d     = '0;
                s1_last_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stage 2: integrate and dump.
    always_comb begin
        ext_i = {{(ACC_W - PW){prod_i_q[PW-1]}}, prod_i_q};
        ext_q = {{(ACC_W - PW){prod_q_q[PW-1]}}, prod_q_q};
        sum_i = acc_i_q + ext_i;
        sum_q = acc_q_q + ext_q;

        acc_i_d   = acc_i_q;
        acc_q_d   = acc_q_q;
        i_sum_d   = i_sum_q;
        q_sum_d   = q_sum_q;
        bit_i_d   = bit_i_q;
        bit_q_d   = bit_q_q;
        sym_vld_d = 1'b0;

        if (mode == FLUSH) begin
            // Drops the stage-1 product and any dump due at this edge.
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (s1_vld_q) begin
            if (s1_last_q) begin
                i_sum_d   = sum_i;
                q_sum_d   = sum_q;
                bit_i_d   = sum_i[ACC_W-1];
                bit_q_d   = sum_q[ACC_W-1];
                sym_vld_d = 1'b1;
                acc_i_d   = '0;
                acc_q_d   = '0;
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            prod_i_q  <= '0;
            prod_q_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            i_sum_q   <= '0;
            q_sum_q   <= '0;
            bit_i_q   <= 1'b0;
            bit_q_q   <= 1'b0;
            sym_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            prod_i_q  <= prod_i_d;
            prod_q_q  <= prod_q_d;
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            i_sum_q   <= i_sum_d;
            q_sum_q   <= q_sum_d;
            bit_i_q   <= bit_i_d;
            bit_q_q   <= bit_q_d;
            sym_vld_q <= sym_vld_d;
        end
    end

    assign bus.i_sum   = i_sum_q;
    assign bus.q_sum   = q_sum_q;
    assign bus.bit_i   = bit_i_q;
    assign bus.bit_q   = bit_q_q;
    assign bus.sym_vld = sym_vld_q;
endmodule
